// File: rtl/bus_read_fifo.sv
// Bus read data stage: producer-side FIFO that pops one word per den assertion,
// registers the word and output enable for the bus driver, and flags overflow/underrun.
//
// state (den_q) | meaning
// 0             | idle, next den high is a read start
// 1             | reading, den already seen high; no further pops until den drops
module bus_read_fifo #(
   parameter int DW     = 8,
   parameter int AW     = 3,
   parameter int UNDVAL = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   input  logic          den,
   output logic [DW-1:0] dout,
   output logic          oe,
   output logic          ovf,
   output logic          udf,
   input  logic          clr_err
);

   localparam int            DEPTH     = 2**AW;
   localparam int            CW        = AW + 1;
   localparam logic [DW-1:0] UND_WORD  = DW'(UNDVAL);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic [DW-1:0] dout_q,   dout_d;
   logic          oe_q,     oe_d;
   logic          ovf_q,    ovf_d;
   logic          udf_q,    udf_d;
   logic          den_q,    den_d;

   logic          full_w;
   logic          empty_w;
   logic          push;
   logic          push_rej;
   logic          start;
   logic          pop;
   logic          start_und;

   // All qualifiers use pre-edge occupancy, so a same-edge push never bypasses to dout.
   always_comb begin
      full_w    = (count_q == DEPTH_CNT);
      empty_w   = (count_q == '0);
      start     = den & ~den_q;
      push      = wr_en & ~full_w;
      push_rej  = wr_en & full_w;
      pop       = start & ~empty_w;
      start_und = start & empty_w;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      oe_d     = den;
      den_d    = den;
      ovf_d    = ovf_q & ~clr_err;
      udf_d    = udf_q & ~clr_err;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         dout_d   = mem_q[rd_ptr_q];
      end else if (start_und) begin
         dout_d   = UND_WORD;
      end
      count_d = count_q + CW'(push) - CW'(pop);

      // Set wins over a same-edge clear.
      if (push_rej) begin
         ovf_d = 1'b1;
      end
      if (start_und) begin
         udf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         oe_q     <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         den_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         oe_q     <= oe_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         den_q    <= den_d;
      end
   end

   // Storage contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign full  = full_w;
   assign empty = empty_w;
   assign count = count_q;
   assign dout  = dout_q;
   assign oe    = oe_q;
   assign ovf   = ovf_q;
   assign udf   = udf_q;

endmodule

// File: tb/tb_bus_read_fifo.sv
// Randomized and directed checks of bus_read_fifo against a queue-based reference model.
module tb_bus_read_fifo;

   localparam int DW     = 8;
   localparam int AW     = 3;
   localparam int DEPTH  = 2**AW;
   localparam int UNDVAL = 0;

   logic          clk;
   logic          rst;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          den;
   logic [DW-1:0] dout;
   logic          oe;
   logic          ovf;
   logic          udf;
   logic          clr_err;

   int n_checks;
   int n_fail;

   logic [DW-1:0] m_q[$];
   logic          m_den_prev;
   logic [DW-1:0] m_dout;
   logic          m_oe;
   logic          m_ovf;
   logic          m_udf;

   bus_read_fifo #(.DW(DW), .AW(AW), .UNDVAL(UNDVAL)) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .empty   (empty),
      .count   (count),
      .den     (den),
      .dout    (dout),
      .oe      (oe),
      .ovf     (ovf),
      .udf     (udf),
      .clr_err (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_den_prev = 1'b0;
      m_dout     = '0;
      m_oe       = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
   endtask

   // One clock edge of the reference behaviour, from pre-edge state and current inputs.
   task automatic model_edge();
      bit was_full;
      bit was_empty;
      bit new_ovf;
      bit new_udf;
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      new_ovf   = 1'b0;
      new_udf   = 1'b0;
      if (den && !m_den_prev) begin
         if (was_empty) begin
            m_dout  = DW'(UNDVAL);
            new_udf = 1'b1;
         end else begin
            m_dout = m_q.pop_front();
         end
      end
      if (wr_en) begin
         if (was_full) new_ovf = 1'b1;
         else          m_q.push_back(wr_data);
      end
      m_ovf      = new_ovf | (m_ovf & ~clr_err);
      m_udf      = new_udf | (m_udf & ~clr_err);
      m_oe       = den;
      m_den_prev = den;
   endtask

   task automatic compare_all();
      chk("count", 32'(count), 32'(m_q.size()));
      chk("full",  32'(full),  32'(m_q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(m_q.size() == 0));
      chk("dout",  32'(dout),  32'(m_dout));
      chk("oe",    32'(oe),    32'(m_oe));
      chk("ovf",   32'(ovf),   32'(m_ovf));
      chk("udf",   32'(udf),   32'(m_udf));
   endtask

   // Called just after a negedge: drive, take one posedge, compare at the next negedge.
   task automatic step(input logic w, input logic [DW-1:0] d, input logic dn, input logic c);
      wr_en   = w;
      wr_data = d;
      den     = dn;
      clr_err = c;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      model_reset();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full",  32'(full),  32'd0);
      chk("rst_dout",  32'(dout),  32'd0);
      chk("rst_oe",    32'(oe),    32'd0);
      chk("rst_ovf",   32'(ovf),   32'd0);
      chk("rst_udf",   32'(udf),   32'd0);
      wr_en   = 1'b0;
      den     = 1'b0;
      clr_err = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse(input int len);
      for (int i = 0; i < len; i++) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      logic den_r;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      wr_en    = 1'b0;
      wr_data  = '0;
      den      = 1'b0;
      clr_err  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Three words out in order, oe one clock late, count 3 -> 0.
      do_reset();
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b0, 1'b0);
      chk("t2_count3", 32'(count), 32'd3);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("t2_dout0", 32'(dout), 32'h11);
      chk("t2_oe_on", 32'(oe), 32'd1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      chk("t2_oe_held", 32'(oe), 32'd1);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("t2_oe_off", 32'(oe), 32'd0);
      chk("t2_dout_hold", 32'(dout), 32'h11);
      pulse(4);
      chk("t2_dout1", 32'(dout), 32'h22);
      pulse(4);
      chk("t2_dout2", 32'(dout), 32'h33);
      chk("t2_count0", 32'(count), 32'd0);

      // Overfill by one, drain with pointer wrap.
      do_reset();
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("t3_full", 32'(full), 32'd1);
      chk("t3_ovf_pre", 32'(ovf), 32'd0);
      step(1'b1, 8'h09, 1'b0, 1'b0);
      chk("t3_ovf", 32'(ovf), 32'd1);
      chk("t3_count", 32'(count), 32'd8);
      for (int i = 1; i <= 8; i++) begin
         pulse(1);
         chk("t3_drain", 32'(dout), 32'(i));
      end
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      pulse(2);
      chk("t3_wrap", 32'(dout), 32'hAA);
      chk("t3_ovf_sticky", 32'(ovf), 32'd1);

      // Read from empty, then clear.
      do_reset();
      step(1'b0, '0, 1'b1, 1'b0);
      chk("t4_dout", 32'(dout), 32'(UNDVAL));
      chk("t4_oe", 32'(oe), 32'd1);
      chk("t4_udf", 32'(udf), 32'd1);
      chk("t4_count", 32'(count), 32'd0);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("t4_clr", 32'(udf), 32'd0);

      // Push on the same edge as a read start.
      do_reset();
      step(1'b1, 8'h05, 1'b0, 1'b0);
      step(1'b1, 8'h06, 1'b0, 1'b0);
      step(1'b1, 8'h07, 1'b1, 1'b0);
      chk("t5_count", 32'(count), 32'd2);
      chk("t5_dout", 32'(dout), 32'h05);
      step(1'b0, '0, 1'b0, 1'b0);
      pulse(1);
      pulse(1);
      chk("t5_dout7", 32'(dout), 32'h07);
      step(1'b1, 8'h08, 1'b1, 1'b0);
      chk("t5_udf", 32'(udf), 32'd1);
      chk("t5_count1", 32'(count), 32'd1);
      chk("t5_dout_und", 32'(dout), 32'(UNDVAL));
      step(1'b0, '0, 1'b0, 1'b0);
      pulse(1);
      chk("t5_kept", 32'(dout), 32'h08);

      // Long den hold pops once; reset mid-hold drops oe at once.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
      chk("t6_count", 32'(count), 32'd2);
      chk("t6_oe", 32'(oe), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("t6_rst_oe", 32'(oe), 32'd0);
      chk("t6_rst_count", 32'(count), 32'd0);
      model_reset();
      #1 rst = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0);

      // Random traffic with persistent den levels and two push densities.
      do_reset();
      den_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic w;
         if ($urandom_range(0, 3) == 0) den_r = ~den_r;
         if (i < 1500) w = ($urandom_range(0, 9) < 6);
         else          w = ($urandom_range(0, 9) < 2);
         step(w, DW'($urandom), den_r, ($urandom_range(0, 19) == 0));
         if (i == 1000) begin
            do_reset();
            den_r = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
